// File: rtl/issue_queue.sv
// Dual-slot in-order issue queue: circular FIFO of decoded instructions feeding two execute units.
// eu0 always takes the head; eu1 may co-issue head+1 when it is ALU-capable and has no RAW on the head.
module issue_queue #(
    parameter int DEPTH = 4,
    parameter int PW    = 128
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic [1:0]              in_valid,
    input  logic [PW-1:0]           in_pld0,
    input  logic [PW-1:0]           in_pld1,
    input  logic [4:0]              in_rd0,
    input  logic [4:0]              in_rj0,
    input  logic [4:0]              in_rk0,
    input  logic [4:0]              in_rd1,
    input  logic [4:0]              in_rj1,
    input  logic [4:0]              in_rk1,
    input  logic                    in_alu0,
    input  logic                    in_alu1,
    output logic [1:0]              in_ready,
    output logic                    eu0_valid,
    input  logic                    eu0_ready,
    output logic [PW-1:0]           eu0_pld,
    output logic [4:0]              eu0_rd,
    output logic [4:0]              eu0_rj,
    output logic [4:0]              eu0_rk,
    output logic                    eu1_valid,
    input  logic                    eu1_ready,
    output logic [PW-1:0]           eu1_pld,
    output logic [4:0]              eu1_rd,
    output logic [4:0]              eu1_rj,
    output logic [4:0]              eu1_rk,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PW-1:0] pld;
        logic [4:0]    rd;
        logic [4:0]    rj;
        logic [4:0]    rk;
        logic          alu;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic [CW-1:0] free;
    entry_t        slot0;
    entry_t        slot1;
    entry_t        wr_a;
    logic          acc0;
    logic          acc1;
    logic          we_a;
    logic          we_b;
    logic          raw;
    logic          fire0;
    logic          fire1;
    logic [1:0]    n_acc;
    logic [1:0]    n_fire;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    assign slot0 = '{pld: in_pld0, rd: in_rd0, rj: in_rj0, rk: in_rk0, alu: in_alu0};
    assign slot1 = '{pld: in_pld1, rd: in_rd1, rj: in_rj1, rk: in_rk1, alu: in_alu1};

    // Enqueue capacity comes only from the registered count, so a full queue never
    // accepts on the strength of a same-cycle issue.
    assign free        = CW'(DEPTH) - count;
    assign in_ready[0] = (free != '0);
    assign in_ready[1] = (free >= CW'(2));

    // Slot1 lands in the first free position when slot0 is idle, otherwise the second.
    assign acc0  = in_valid[0] & in_ready[0] & ~flush;
    assign acc1  = in_valid[1] & ~flush & (in_valid[0] ? (acc0 & in_ready[1]) : in_ready[0]);
    assign we_a  = acc0 | acc1;
    assign we_b  = acc0 & acc1;
    assign wr_a  = in_valid[0] ? slot0 : slot1;
    assign n_acc = {1'b0, acc0} + {1'b0, acc1};

    assign raw = (mem[head].rd != 5'd0) &
                 ((mem[head].rd == mem[head_p1].rj) | (mem[head].rd == mem[head_p1].rk));

    assign eu0_valid = (count != '0) & ~flush;
    assign eu1_valid = (count >= CW'(2)) & eu0_valid & eu0_ready & mem[head_p1].alu & ~raw;
    assign fire0     = eu0_valid & eu0_ready;
    assign fire1     = eu1_valid & eu1_ready;
    assign n_fire    = {1'b0, fire0} + {1'b0, fire1};

    assign eu0_pld = mem[head].pld;
    assign eu0_rd  = mem[head].rd;
    assign eu0_rj  = mem[head].rj;
    assign eu0_rk  = mem[head].rk;
    assign eu1_pld = mem[head_p1].pld;
    assign eu1_rd  = mem[head_p1].rd;
    assign eu1_rj  = mem[head_p1].rj;
    assign eu1_rk  = mem[head_p1].rk;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_fire);
            tail  <= tail + AW'(n_acc);
            count <= count + CW'(n_acc) - CW'(n_fire);
        end
    end

    // NOTE: payload storage has no reset; count gates validity, so stale contents are never issued.
    always_ff @(posedge clk) begin
        if (we_a) mem[tail]    <= wr_a;
        if (we_b) mem[tail_p1] <= slot1;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue (DEPTH=4): table of per-cycle vectors plus a mid-operation reset sequence.
module tb_issue_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic [1:0]    in_valid;
    logic [PW-1:0] in_pld0, in_pld1;
    logic [4:0]    in_rd0, in_rj0, in_rk0, in_rd1, in_rj1, in_rk1;
    logic          in_alu0, in_alu1;
    logic [1:0]    in_ready;
    logic          eu0_valid, eu0_ready, eu1_valid, eu1_ready;
    logic [PW-1:0] eu0_pld, eu1_pld;
    logic [4:0]    eu0_rd, eu0_rj, eu0_rk, eu1_rd, eu1_rj, eu1_rk;
    logic [2:0]    count;

    int tests = 0;
    int fails = 0;

    issue_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_pld0(in_pld0), .in_pld1(in_pld1),
        .in_rd0(in_rd0), .in_rj0(in_rj0), .in_rk0(in_rk0),
        .in_rd1(in_rd1), .in_rj1(in_rj1), .in_rk1(in_rk1),
        .in_alu0(in_alu0), .in_alu1(in_alu1), .in_ready(in_ready),
        .eu0_valid(eu0_valid), .eu0_ready(eu0_ready), .eu0_pld(eu0_pld),
        .eu0_rd(eu0_rd), .eu0_rj(eu0_rj), .eu0_rk(eu0_rk),
        .eu1_valid(eu1_valid), .eu1_ready(eu1_ready), .eu1_pld(eu1_pld),
        .eu1_rd(eu1_rd), .eu1_rj(eu1_rj), .eu1_rk(eu1_rk),
        .count(count)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle, and the outputs expected while they are applied.
    typedef struct {
        logic          fl;
        logic [1:0]    iv;
        logic [PW-1:0] p0, p1;
        logic          a0, a1;
        logic [4:0]    rd0, rj0, rk0, rd1, rj1, rk1;
        logic [1:0]    rdy;
        logic [2:0]    e_cnt;
        logic [1:0]    e_ir;
        logic          e_v0, e_v1;
        logic [PW-1:0] e_p0, e_p1;
        logic [4:0]    e_rd0;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic [1:0] iv, input logic [PW-1:0] p0, p1,
                       input logic a0, a1, input logic [4:0] rd0, rj0, rk0, rd1, rj1, rk1,
                       input logic [1:0] rdy, input logic [2:0] e_cnt, input logic [1:0] e_ir,
                       input logic e_v0, e_v1, input logic [PW-1:0] e_p0, e_p1, input logic [4:0] e_rd0);
        vec_t v;
        v.fl = fl; v.iv = iv; v.p0 = p0; v.p1 = p1; v.a0 = a0; v.a1 = a1;
        v.rd0 = rd0; v.rj0 = rj0; v.rk0 = rk0; v.rd1 = rd1; v.rj1 = rj1; v.rk1 = rk1;
        v.rdy = rdy; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_v0 = e_v0; v.e_v1 = e_v1;
        v.e_p0 = e_p0; v.e_p1 = e_p1; v.e_rd0 = e_rd0;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        flush = 0; in_valid = 2'b00; in_pld0 = '0; in_pld1 = '0;
        in_rd0 = 0; in_rj0 = 0; in_rk0 = 0; in_rd1 = 0; in_rj1 = 0; in_rk1 = 0;
        in_alu0 = 0; in_alu1 = 0; eu0_ready = 0; eu1_ready = 0;
    endtask

    initial begin
        //   fl iv     p0       p1       a0 a1 rd0 rj0 rk0 rd1 rj1 rk1 rdy   cnt ir     v0 v1 e_p0     e_p1     e_rd0
        // Dual enqueue then dual issue on independent ALU pair
        add(0, 2'b11, 16'hA0A0, 16'hA1A1, 1, 1, 5, 1, 2, 8, 6, 7, 2'b11, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2'b11, 1, 1, 16'hA0A0, 16'hA1A1, 5);
        // RAW: head rd=5, head+1 rj=5 blocks eu1
        add(0, 2'b11, 16'hB0B0, 16'hB1B1, 0, 1, 5, 0, 0, 3, 5, 9, 2'b11, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2'b11, 1, 0, 16'hB0B0, 16'h0,    5);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b11, 1, 0, 16'hB1B1, 16'h0,    3);
        // rd=0 never creates a dependence
        add(0, 2'b11, 16'hC0C0, 16'hC1C1, 0, 1, 0, 3, 4, 2, 0, 0, 2'b00, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2'b11, 1, 1, 16'hC0C0, 16'hC1C1, 0);
        // Non-ALU head+1 cannot co-issue
        add(0, 2'b11, 16'hD0D0, 16'hD1D1, 0, 0, 1, 0, 0, 6, 2, 3, 2'b00, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2, 2'b11, 1, 0, 16'hD0D0, 16'h0,    1);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b11, 1, 0, 16'hD1D1, 16'h0,    6);
        // Fill to full with tail wrap; eu1_ready alone issues nothing
        add(0, 2'b11, 16'hE0E0, 16'hE1E1, 1, 1, 0, 0, 0, 7, 1, 1, 2'b00, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);
        add(0, 2'b11, 16'hE2E2, 16'hE3E3, 1, 1, 4, 0, 0, 9, 4, 0, 2'b10, 2, 2'b11, 1, 0, 16'hE0E0, 16'h0,    0);
        add(0, 2'b11, 16'hE4E4, 16'hE5E5, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4, 2'b00, 1, 0, 16'hE0E0, 16'h0,    0);
        // Full queue: issue both, enqueue nothing
        add(0, 2'b11, 16'hE6E6, 16'hE7E7, 1, 1, 0, 0, 0, 0, 0, 0, 2'b11, 4, 2'b00, 1, 1, 16'hE0E0, 16'hE1E1, 0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2, 2'b11, 1, 0, 16'hE2E2, 16'h0,    4);
        // Reach count=3, then flush with enqueue and eu0_ready asserted
        add(0, 2'b01, 16'hF0F0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2, 2'b11, 1, 0, 16'hE2E2, 16'h0,    4);
        add(1, 2'b11, 16'hF1F1, 16'hF2F2, 1, 1, 0, 0, 0, 0, 0, 0, 2'b11, 3, 2'b01, 0, 0, 16'h0,    16'h0,    0);
        // Slot1 alone on empty queue goes to the head
        add(0, 2'b10, 16'h6060, 16'h6161, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);
        add(0, 2'b11, 16'h7070, 16'h7171, 1, 1, 0, 0, 0, 12, 0, 0, 2'b00, 1, 2'b11, 1, 0, 16'h6161, 16'h0,   0);
        // One free entry: only slot0 accepted
        add(0, 2'b11, 16'h8080, 16'h8181, 0, 1, 13, 0, 0, 0, 0, 0, 2'b00, 3, 2'b01, 1, 0, 16'h6161, 16'h0,   0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 4, 2'b00, 1, 1, 16'h6161, 16'h7070, 0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 2'b01, 1, 1, 16'h7070, 16'h7171, 0);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 2'b11, 1, 0, 16'h8080, 16'h0,   13);
        add(0, 2'b00, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0, 16'h0,    16'h0,    0);

        rstn = 1'b0;
        drive_idle();
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 32'h3);
        check("rst_eu0_valid", 32'(eu0_valid), 0);
        check("rst_eu1_valid", 32'(eu1_valid), 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_pld0 = vecs[i].p0; in_pld1 = vecs[i].p1;
            in_alu0 = vecs[i].a0; in_alu1 = vecs[i].a1;
            in_rd0 = vecs[i].rd0; in_rj0 = vecs[i].rj0; in_rk0 = vecs[i].rk0;
            in_rd1 = vecs[i].rd1; in_rj1 = vecs[i].rj1; in_rk1 = vecs[i].rk1;
            eu0_ready = vecs[i].rdy[0]; eu1_ready = vecs[i].rdy[1];
            #1;
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            check($sformatf("v%0d_eu0_valid", i), 32'(eu0_valid), 32'(vecs[i].e_v0));
            check($sformatf("v%0d_eu1_valid", i), 32'(eu1_valid), 32'(vecs[i].e_v1));
            if (vecs[i].e_v0) begin
                check($sformatf("v%0d_eu0_pld", i), 32'(eu0_pld), 32'(vecs[i].e_p0));
                check($sformatf("v%0d_eu0_rd", i), 32'(eu0_rd), 32'(vecs[i].e_rd0));
            end
            if (vecs[i].e_v1)
                check($sformatf("v%0d_eu1_pld", i), 32'(eu1_pld), 32'(vecs[i].e_p1));
        end

        // Asynchronous reset in mid-operation drops both queued entries.
        @(negedge clk);
        drive_idle();
        in_valid = 2'b11; in_pld0 = 16'h9090; in_pld1 = 16'h9191; in_rj0 = 5'd17;
        @(negedge clk);
        in_valid = 2'b00;
        #1;
        check("pre_rst_count", 32'(count), 2);
        check("pre_rst_eu0_rj", 32'(eu0_rj), 17);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_in_ready", 32'(in_ready), 32'h3);
        check("async_rst_eu0_valid", 32'(eu0_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        in_valid = 2'b01; in_pld0 = 16'hABCD; in_rd0 = 5'd9;
        @(negedge clk);
        in_valid = 2'b00;
        #1;
        check("post_rst_count", 32'(count), 1);
        check("post_rst_eu0_valid", 32'(eu0_valid), 1);
        check("post_rst_eu0_pld", 32'(eu0_pld), 32'hABCD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
